instr_fetch: RTL and testbench

Instruction fetch unit that produces the 9-bit `Instruction` word consumed by the control decoder. It owns the program counter and drives a synchronous-read instruction ROM. It redirects on taken branches, holds on datapath stalls through a one-entry skid buffer, and halts on the all-ones halt word. It sits between the instruction ROM and the `Ctrl`/datapath stage, and takes `BranchEn` back from the decoder.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_fetch_skid.sv | 41 ++++
 rtl/instr_fetch.sv | 164 ++++++++++++++++
 tb/tb_instr_fetch.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Definitions: types and constants shared by the instruction fetch slice.
//   fetch_state_t   : fetch FSM states (IDLE, REDIR, RUN, HALT)
//   HALT_INSTR      : the all-ones instruction word that halts the program
//   PC_W_DEFAULT    : default program counter / ROM address width
//   INSTR_W_DEFAULT : default instruction width
package Definitions;

    localparam int PC_W_DEFAULT    = 10;
    localparam int INSTR_W_DEFAULT = 9;

    localparam logic [8:0] HALT_INSTR = 9'b111111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM bus plus decoder/datapath signals of the fetch unit.
//   RomAddr      : registered ROM read address (fetch -> ROM)
//   RomData      : synchronous ROM output, mem[RomAddr of previous cycle]
//   BranchEn     : decoder flags the current Instruction as a branch
//   BranchTaken  : branch condition from the ALU
//   BranchTarget : resolved branch target address
//   Stall        : datapath is not consuming Instruction this cycle
//   Instruction  : current instruction word
//   InstrValid   : Instruction is real, not a bubble
//   PC           : address of Instruction
//   Done         : program halted (level)
// modport master is the fetch unit, modport slave is the ROM/decoder side.
interface instr_fetch_if
    import Definitions::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
);

    logic [PC_W-1:0]    RomAddr;
    logic [INSTR_W-1:0] RomData;
    logic               BranchEn;
    logic               BranchTaken;
    logic [PC_W-1:0]    BranchTarget;
    logic               Stall;
    logic [INSTR_W-1:0] Instruction;
    logic               InstrValid;
    logic [PC_W-1:0]    PC;
    logic               Done;

    modport master (
        output RomAddr, Instruction, InstrValid, PC, Done,
        input  RomData, BranchEn, BranchTaken, BranchTarget, Stall
    );

    modport slave (
        input  RomAddr, Instruction, InstrValid, PC, Done,
        output RomData, BranchEn, BranchTaken, BranchTarget, Stall
    );

endinterface

// File: rtl/instr_fetch_skid.sv
// fetch_skid: one-entry skid buffer holding {address, ROM word}.
//   Clk, Reset_n : clock and asynchronous active-low reset
//   capture      : load addr_in/data_in and mark the entry valid
//   clear        : empty the entry (wins over capture)
//   addr_in      : address of the word on data_in
//   data_in      : ROM word to park
//   valid        : entry holds a parked word
//   addr_out     : parked address
//   data_out     : parked ROM word
module fetch_skid
    import Definitions::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               capture,
    input  logic               clear,
    input  logic [PC_W-1:0]    addr_in,
    input  logic [INSTR_W-1:0] data_in,
    output logic               valid,
    output logic [PC_W-1:0]    addr_out,
    output logic [INSTR_W-1:0] data_out
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid    <= 1'b0;
            addr_out <= '0;
            data_out <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid    <= 1'b1;
            addr_out <= addr_in;
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit driving a synchronous-read ROM.
//   Clk        : clock, rising edge
//   Reset_n    : asynchronous active-low reset
//   Start      : one-cycle pulse, honoured in IDLE or HALT only
//   StartAddr  : first instruction address, sampled with Start
//   InstrCount : consumed-instruction counter (only with FETCH_PERF_EN)
//   bus        : instr_fetch_if.master (ROM bus, branch inputs, Stall,
//                Instruction/InstrValid/PC/Done outputs)
// Optional feature macro: FETCH_PERF_EN adds the saturating InstrCount.
module instr_fetch
    import Definitions::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
`ifdef FETCH_PERF_EN
    output logic [15:0]     InstrCount,
`endif
    instr_fetch_if.master   bus
);

    localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(HALT_INSTR);

    fetch_state_t       state, next_state;
    logic [PC_W-1:0]    rom_addr, next_rom_addr;
    logic [PC_W-1:0]    fpc, next_fpc;
    logic [INSTR_W-1:0] instr, next_instr;
    logic [PC_W-1:0]    pc, next_pc;
    logic               instr_valid, next_valid;
    logic               done, next_done;
    logic               start_accept;

    logic               skid_capture;
    logic               skid_clear;
    logic               skid_valid;
    logic [PC_W-1:0]    skid_addr;
    logic [INSTR_W-1:0] skid_data;

    // While stalled the ROM keeps reading the held RomAddr, so the word that
    // was on RomData in the first stall cycle is lost unless parked here.
    fetch_skid #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .capture  (skid_capture),
        .clear    (skid_clear),
        .addr_in  (fpc),
        .data_in  (bus.RomData),
        .valid    (skid_valid),
        .addr_out (skid_addr),
        .data_out (skid_data)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            fpc         <= '0;
            instr       <= '0;
            pc          <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= next_state;
            rom_addr    <= next_rom_addr;
            fpc         <= next_fpc;
            instr       <= next_instr;
            pc          <= next_pc;
            instr_valid <= next_valid;
            done        <= next_done;
        end
    end

    // Stall outranks branch and halt: both are only acted on in the cycle
    // the current instruction is actually consumed.
    always_comb begin
        next_state    = state;
        next_rom_addr = rom_addr;
        next_fpc      = rom_addr;
        next_instr    = instr;
        next_pc       = pc;
        next_valid    = instr_valid;
        next_done     = done;
        start_accept  = 1'b0;
        skid_capture  = 1'b0;
        skid_clear    = 1'b0;

        unique case (state)
            IDLE, HALT: begin
                if (Start) begin
                    start_accept  = 1'b1;
                    next_rom_addr = StartAddr;
                    next_done     = 1'b0;
                    next_valid    = 1'b0;
                    next_state    = REDIR;
                end
            end

            // RomData here still belongs to the old address; just advance.
            REDIR: begin
                next_valid    = 1'b0;
                next_rom_addr = rom_addr + PC_W'(1);
                next_state    = RUN;
            end

            RUN: begin
                if (bus.Stall) begin
                    next_fpc     = fpc;
                    skid_capture = ~skid_valid;
                end else begin
                    skid_clear = 1'b1;
                    if (instr_valid && (instr == HALT_WORD)) begin
                        next_valid = 1'b0;
                        next_done  = 1'b1;
                        next_state = HALT;
                    end else if (instr_valid && bus.BranchEn && bus.BranchTaken) begin
                        next_rom_addr = bus.BranchTarget;
                        next_valid    = 1'b0;
                        next_state    = REDIR;
                    end else begin
                        next_instr    = skid_valid ? skid_data : bus.RomData;
                        next_pc       = skid_valid ? skid_addr : fpc;
                        next_valid    = 1'b1;
                        next_rom_addr = rom_addr + PC_W'(1);
                    end
                end
            end

            default: next_state = IDLE;
        endcase
    end

`ifdef FETCH_PERF_EN
    logic [15:0] instr_count;
    logic        count_en;

    assign count_en = (state == RUN) && instr_valid && !bus.Stall;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_count <= '0;
        end else if (start_accept) begin
            instr_count <= '0;
        end else if (count_en && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    assign InstrCount = instr_count;
`endif

    assign bus.RomAddr     = rom_addr;
    assign bus.Instruction = instr;
    assign bus.InstrValid  = instr_valid;
    assign bus.PC          = pc;
    assign bus.Done        = done;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch with a ROM model and
// an expected-instruction scoreboard queue.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    logic                Clk       = 1'b0;
    logic                Reset_n   = 1'b1;
    logic                Start     = 1'b0;
    logic [PC_W-1:0]     StartAddr = '0;
`ifdef FETCH_PERF_EN
    logic [15:0]         InstrCount;
`endif

    logic [INSTR_W-1:0]  mem [0:(1<<PC_W)-1];
    exp_t                expq [$];
    int                  total = 0;
    int                  bad   = 0;

    instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .StartAddr  (StartAddr),
`ifdef FETCH_PERF_EN
        .InstrCount (InstrCount),
`endif
        .bus        (bus)
    );

    always #5 Clk = ~Clk;

    // Synchronous-read ROM
    always @(posedge Clk) bus.RomData <= mem[bus.RomAddr];

    task automatic push_exp(input logic [PC_W-1:0] a);
        expq.push_back('{pc: a, instr: mem[a]});
    endtask

    task automatic do_reset();
        Reset_n          = 1'b0;
        Start            = 1'b0;
        bus.Stall        = 1'b0;
        bus.BranchEn     = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = '0;
        expq.delete();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after Start
    task automatic start_pulse(input logic [PC_W-1:0] a);
        Start     = 1'b1;
        StartAddr = a;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        Reset_n = 1'b0;
        @(negedge Clk);
        total++;
        if (bus.RomAddr !== 10'd0 || bus.PC !== 10'd0 || bus.Instruction !== 9'd0) begin
            bad++;
            $display("[TB] FAIL reset_regs: got addr=%0d pc=%0d instr=%h, expected 0 0 000",
                     bus.RomAddr, bus.PC, bus.Instruction);
        end
        total++;
        if (bus.InstrValid !== 1'b0 || bus.Done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got valid=%b done=%b, expected 0 0",
                     bus.InstrValid, bus.Done);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (InstrCount !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_count: got %0d, expected 0", InstrCount);
        end
`endif
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        total++;
        if (bus.InstrValid !== 1'b0 || bus.RomAddr !== 10'd0) begin
            bad++;
            $display("[TB] FAIL idle_hold: got valid=%b addr=%0d, expected 0 0",
                     bus.InstrValid, bus.RomAddr);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        int   first_valid = -1;
        do_reset();
        push_exp(10'd5);
        push_exp(10'd6);
        push_exp(10'd7);
        start_pulse(10'd5);
        for (int c = 1; c <= 9; c++) begin
            if (bus.InstrValid) begin
                if (first_valid < 0) first_valid = c;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL seq_extra: got pc=%0d, expected no instruction", bus.PC);
                end else begin
                    e = expq.pop_front();
                    if (bus.PC !== e.pc || bus.Instruction !== e.instr) begin
                        bad++;
                        $display("[TB] FAIL seq_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                                 bus.PC, bus.Instruction, e.pc, e.instr);
                    end
                end
            end
            if (c == 5) begin
                total++;
                if (bus.Done !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL seq_done_early: got %b, expected 0", bus.Done);
                end
            end
            if (c >= 6) begin
                total++;
                if (bus.Done !== 1'b1 || bus.InstrValid !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL seq_halted c=%0d: got done=%b valid=%b, expected 1 0",
                             c, bus.Done, bus.InstrValid);
                end
            end
            @(negedge Clk);
        end
        total++;
        if (first_valid != 3) begin
            bad++;
            $display("[TB] FAIL seq_latency: got cycle %0d, expected 3", first_valid);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL seq_missing: got %0d left, expected 0", expq.size());
        end
`ifdef FETCH_PERF_EN
        total++;
        if (InstrCount !== 16'd3) begin
            bad++;
            $display("[TB] FAIL seq_count: got %0d, expected 3", InstrCount);
        end
`endif
        start_pulse(10'd30);
        total++;
        if (bus.Done !== 1'b0 || bus.InstrValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL restart_clear: got done=%b valid=%b, expected 0 0",
                     bus.Done, bus.InstrValid);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (InstrCount !== 16'd0) begin
            bad++;
            $display("[TB] FAIL restart_count: got %0d, expected 0", InstrCount);
        end
`endif
    endtask

    task automatic test_branch();
        exp_t e;
        int   c12 = -100;
        do_reset();
        push_exp(10'd10);
        push_exp(10'd11);
        push_exp(10'd12);
        push_exp(10'd40);
        push_exp(10'd41);
        start_pulse(10'd10);
        for (int c = 1; c <= 20 && expq.size() > 0; c++) begin
            bus.BranchEn     = 1'b0;
            bus.BranchTaken  = 1'b0;
            bus.BranchTarget = 10'd40;
            if (bus.InstrValid && bus.PC == 10'd11) begin
                bus.BranchEn = 1'b1;
            end else if (bus.InstrValid && bus.PC == 10'd12) begin
                bus.BranchEn    = 1'b1;
                bus.BranchTaken = 1'b1;
                c12             = c;
            end
            if (bus.InstrValid) begin
                total++;
                e = expq.pop_front();
                if (bus.PC !== e.pc || bus.Instruction !== e.instr) begin
                    bad++;
                    $display("[TB] FAIL br_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.PC, bus.Instruction, e.pc, e.instr);
                end
                if (e.pc == 10'd40) begin
                    total++;
                    if (c != c12 + 3) begin
                        bad++;
                        $display("[TB] FAIL br_bubbles: got target at cycle %0d, expected %0d",
                                 c, c12 + 3);
                    end
                end
            end
            @(negedge Clk);
        end
        bus.BranchEn    = 1'b0;
        bus.BranchTaken = 1'b0;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL br_missing: got %0d left, expected 0", expq.size());
        end
    endtask

    task automatic test_stall();
        exp_t e;
        int   c20   = -100;
        int   left  = 0;
        bit   armed = 1'b0;
        do_reset();
        for (int a = 18; a <= 22; a++) push_exp(PC_W'(a));
        start_pulse(10'd18);
        for (int c = 1; c <= 25 && expq.size() > 0; c++) begin
            if (!armed && bus.InstrValid && bus.PC == 10'd20) begin
                armed     = 1'b1;
                left      = 3;
                c20       = c;
                bus.Stall = 1'b1;
            end else if (left > 0) begin
                left--;
                if (left == 0) bus.Stall = 1'b0;
            end
            if (bus.Stall) begin
                total++;
                if (bus.InstrValid !== 1'b1 || bus.PC !== 10'd20 || bus.Instruction !== mem[10'd20]) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: got valid=%b pc=%0d instr=%h, expected 1 20 %h",
                             bus.InstrValid, bus.PC, bus.Instruction, mem[10'd20]);
                end
            end
            if (bus.InstrValid && !bus.Stall) begin
                total++;
                e = expq.pop_front();
                if (bus.PC !== e.pc || bus.Instruction !== e.instr) begin
                    bad++;
                    $display("[TB] FAIL stall_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.PC, bus.Instruction, e.pc, e.instr);
                end
                if (e.pc == 10'd21) begin
                    total++;
                    if (c != c20 + 4) begin
                        bad++;
                        $display("[TB] FAIL stall_length: got pc21 at cycle %0d, expected %0d",
                                 c, c20 + 4);
                    end
                end
            end
            @(negedge Clk);
        end
        bus.Stall = 1'b0;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL stall_missing: got %0d left, expected 0", expq.size());
        end
    endtask

    task automatic test_stall_branch();
        exp_t e;
        int   rel   = -100;
        int   left  = 0;
        bit   armed = 1'b0;
        do_reset();
        push_exp(10'd8);
        push_exp(10'd100);
        push_exp(10'd101);
        start_pulse(10'd8);
        for (int c = 1; c <= 20 && expq.size() > 0; c++) begin
            if (!armed && bus.InstrValid && bus.PC == 10'd8) begin
                armed            = 1'b1;
                left             = 2;
                bus.Stall        = 1'b1;
                bus.BranchEn     = 1'b1;
                bus.BranchTaken  = 1'b1;
                bus.BranchTarget = 10'd100;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    bus.Stall = 1'b0;
                    rel       = c;
                end
            end else begin
                bus.BranchEn    = 1'b0;
                bus.BranchTaken = 1'b0;
            end
            if (bus.Stall) begin
                total++;
                if (bus.InstrValid !== 1'b1 || bus.PC !== 10'd8) begin
                    bad++;
                    $display("[TB] FAIL sbr_hold: got valid=%b pc=%0d, expected 1 8",
                             bus.InstrValid, bus.PC);
                end
            end
            if (bus.InstrValid && !bus.Stall) begin
                total++;
                e = expq.pop_front();
                if (bus.PC !== e.pc || bus.Instruction !== e.instr) begin
                    bad++;
                    $display("[TB] FAIL sbr_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.PC, bus.Instruction, e.pc, e.instr);
                end
                if (e.pc == 10'd100) begin
                    total++;
                    if (c != rel + 3) begin
                        bad++;
                        $display("[TB] FAIL sbr_latency: got target at cycle %0d, expected %0d",
                                 c, rel + 3);
                    end
                end
            end
            @(negedge Clk);
        end
        bus.BranchEn    = 1'b0;
        bus.BranchTaken = 1'b0;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL sbr_missing: got %0d left, expected 0", expq.size());
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        do_reset();
        push_exp(10'd1022);
        push_exp(10'd1023);
        push_exp(10'd0);
        push_exp(10'd1);
        start_pulse(10'd1022);
        for (int c = 1; c <= 15 && expq.size() > 0; c++) begin
            if (bus.InstrValid) begin
                total++;
                e = expq.pop_front();
                if (bus.PC !== e.pc || bus.Instruction !== e.instr) begin
                    bad++;
                    $display("[TB] FAIL wrap_order: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.PC, bus.Instruction, e.pc, e.instr);
                end
            end
            @(negedge Clk);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL wrap_missing: got %0d left, expected 0", expq.size());
        end
    endtask

    task automatic test_restart();
        exp_t e;
        do_reset();
        for (int a = 200; a <= 204; a++) push_exp(PC_W'(a));
        start_pulse(10'd200);
        for (int c = 1; c <= 20 && expq.size() > 0; c++) begin
            Start = 1'b0;
            if (bus.InstrValid && bus.PC == 10'd201) begin
                Start     = 1'b1;
                StartAddr = 10'd500;
            end
            if (bus.InstrValid) begin
                total++;
                e = expq.pop_front();
                if (bus.PC !== e.pc || bus.Instruction !== e.instr) begin
                    bad++;
                    $display("[TB] FAIL run_start_ignored: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             bus.PC, bus.Instruction, e.pc, e.instr);
                end
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL run_missing: got %0d left, expected 0", expq.size());
        end
        // Reset asserted mid-cycle, well away from a rising edge
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (bus.RomAddr !== 10'd0 || bus.PC !== 10'd0 || bus.Instruction !== 9'd0 ||
            bus.InstrValid !== 1'b0 || bus.Done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got addr=%0d pc=%0d instr=%h valid=%b done=%b, expected all 0",
                     bus.RomAddr, bus.PC, bus.Instruction, bus.InstrValid, bus.Done);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (InstrCount !== 16'd0) begin
            bad++;
            $display("[TB] FAIL async_reset_count: got %0d, expected 0", InstrCount);
        end
`endif
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) begin
            mem[i[PC_W-1:0]] = i[INSTR_W-1:0] ^ 9'h055;
        end
        mem[10'd5] = 9'h021;
        mem[10'd6] = 9'h0A4;
        mem[10'd7] = 9'h1FF;

        bus.Stall        = 1'b0;
        bus.BranchEn     = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = '0;
        #1;

        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_stall_branch();
        test_wrap();
        test_restart();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
